fetch_sequencer: RTL

- Front-end consumer of the branch decision: holds the PC and issues in-order instruction-fetch requests to instruction memory.
- Buffers returned instructions with their PCs and presents them to decode over a valid/ready handshake.
- On a taken branch or jump redirect, it reloads the PC and squashes every fetch that is in flight or buffered.

---
 rtl/fetch_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: holds the PC, issues in-order fetch requests to instruction
// memory, buffers returned words with their PCs in a small fetch queue and
// hands them to decode over valid/ready. A redirect reloads the PC, flushes
// the queues and turns every in-flight request into a drop.
// Build option: FETCH_MISALIGN_TRAP_EN -- when defined, a misaligned redirect
// target stalls fetch and presents one trap entry flagged on if_misalign;
// when undefined, target bits [1:0] are silently cleared.
module fetch_sequencer #(
    parameter int           n        = 32,
    parameter logic [n-1:0] RESET_PC = 32'h0000_0000,
    parameter int           FQ_DEPTH = 2
) (
    input  logic         clock,
    input  logic         nReset,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [n-1:0] imem_rdata,
    input  logic         redir_valid,
    input  logic [n-1:0] redir_target,
    output logic         if_valid,
    output logic [n-1:0] if_instr,
    output logic [n-1:0] if_pc,
    input  logic         if_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic         if_misalign
`endif
);

    localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int SW = CW + 2;

    localparam logic [AW-1:0] PTR_ZERO   = AW'(1'b0);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [n-1:0]  PC_STEP    = n'(3'd4);
    localparam logic [n-1:0]  WORD_ZERO  = n'(1'b0);
    localparam logic [n-1:0]  ALIGN_MASK = ~(n'(2'b11));

    // architectural state
    logic [n-1:0]  pc_r;
    logic [CW-1:0] out_r, drop_r, cnt_r;
    logic [AW-1:0] fq_rd_r, fq_wr_r, ip_rd_r, ip_wr_r;
    logic [n-1:0]  fq_pc_r    [FQ_DEPTH];
    logic [n-1:0]  fq_instr_r [FQ_DEPTH];
    logic [n-1:0]  ip_pc_r    [FQ_DEPTH];

    // registered outputs
    logic          imem_req_r, if_valid_r;
    logic [n-1:0]  if_instr_r, if_pc_r;

    // next-state and handshake decode
    logic          gnt_fire_s, pop_s, resp_drop_s, resp_take_s, push_s;
    logic [CW-1:0] out_after_s, drop_after_s, cnt_after_pop_s;
    logic [CW-1:0] out_nxt_s, drop_nxt_s, cnt_nxt_s;
    logic [AW-1:0] fq_rd_adv_s, fq_rd_nxt_s, fq_wr_nxt_s, ip_rd_nxt_s, ip_wr_nxt_s;
    logic [n-1:0]  pc_nxt_s, head_pc_s, head_instr_s;
    logic [SW-1:0] credit_s;
    logic          req_nxt_s, valid_nxt_s;
    logic [n-1:0]  if_pc_nxt_s, if_instr_nxt_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic          trap_r, stall_r;
    logic [n-1:0]  trap_pc_r;
    logic          trap_nxt_s, stall_nxt_s;
    logic [n-1:0]  trap_pc_nxt_s;
`endif

    // Decode this cycle's handshakes and compute every counter/pointer update.
    always_comb begin
        gnt_fire_s      = imem_req_r & imem_gnt;
        pop_s           = if_valid_r & if_ready & (cnt_r != CNT_ZERO);
        resp_drop_s     = imem_rvalid & (drop_r != CNT_ZERO);
        // a response with nothing outstanding is a protocol error and is ignored
        resp_take_s     = imem_rvalid & (drop_r == CNT_ZERO) & (out_r != CNT_ZERO);
        push_s          = resp_take_s & ~redir_valid;
        out_after_s     = out_r + (gnt_fire_s ? CNT_ONE : CNT_ZERO)
                                - (resp_take_s ? CNT_ONE : CNT_ZERO);
        drop_after_s    = drop_r - (resp_drop_s ? CNT_ONE : CNT_ZERO);
        cnt_after_pop_s = cnt_r - (pop_s ? CNT_ONE : CNT_ZERO);
        fq_rd_adv_s     = fq_rd_r + (pop_s ? PTR_ONE : PTR_ZERO);
        if (redir_valid) begin
            // everything still in flight, including a request granted now, becomes a drop
            pc_nxt_s    = redir_target & ALIGN_MASK;
            out_nxt_s   = CNT_ZERO;
            drop_nxt_s  = drop_after_s + out_after_s;
            cnt_nxt_s   = CNT_ZERO;
            fq_rd_nxt_s = PTR_ZERO;
            fq_wr_nxt_s = PTR_ZERO;
            ip_rd_nxt_s = PTR_ZERO;
            ip_wr_nxt_s = PTR_ZERO;
        end else begin
            pc_nxt_s    = gnt_fire_s ? (pc_r + PC_STEP) : pc_r;
            out_nxt_s   = out_after_s;
            drop_nxt_s  = drop_after_s;
            cnt_nxt_s   = cnt_after_pop_s + (push_s ? CNT_ONE : CNT_ZERO);
            fq_rd_nxt_s = fq_rd_adv_s;
            fq_wr_nxt_s = fq_wr_r + (push_s ? PTR_ONE : PTR_ZERO);
            ip_rd_nxt_s = ip_rd_r + (resp_take_s ? PTR_ONE : PTR_ZERO);
            ip_wr_nxt_s = ip_wr_r + (gnt_fire_s ? PTR_ONE : PTR_ZERO);
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Trap entry lifetime: raised by a misaligned redirect, retired by a decode pop.
    always_comb begin
        if (redir_valid) begin
            trap_nxt_s    = (redir_target[1:0] != 2'b00);
            stall_nxt_s   = (redir_target[1:0] != 2'b00);
            trap_pc_nxt_s = redir_target;
        end else begin
            trap_nxt_s    = trap_r & ~(if_valid_r & if_ready);
            stall_nxt_s   = stall_r;
            trap_pc_nxt_s = trap_pc_r;
        end
    end
`endif

    // Next values of the registered outputs: credit-based request and queue head.
    always_comb begin
        credit_s = SW'(out_nxt_s) + SW'(drop_nxt_s) + SW'(cnt_nxt_s);
        req_nxt_s = (credit_s < SW'(FQ_DEPTH));
        // an empty queue receiving a push exposes the pushed entry directly
        if (push_s && (cnt_after_pop_s == CNT_ZERO)) begin
            head_pc_s    = ip_pc_r[ip_rd_r];
            head_instr_s = imem_rdata;
        end else begin
            head_pc_s    = fq_pc_r[fq_rd_adv_s];
            head_instr_s = fq_instr_r[fq_rd_adv_s];
        end
        valid_nxt_s    = (cnt_nxt_s != CNT_ZERO);
        if_pc_nxt_s    = head_pc_s;
        if_instr_nxt_s = head_instr_s;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (stall_nxt_s) begin
            req_nxt_s = 1'b0;
        end else begin
            req_nxt_s = req_nxt_s;
        end
        if (trap_nxt_s) begin
            valid_nxt_s    = 1'b1;
            if_pc_nxt_s    = trap_pc_nxt_s;
            if_instr_nxt_s = WORD_ZERO;
        end else begin
            valid_nxt_s    = valid_nxt_s;
        end
`endif
    end

    // PC, counters, both FIFOs and the registered outputs.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            pc_r       <= RESET_PC;
            out_r      <= CNT_ZERO;
            drop_r     <= CNT_ZERO;
            cnt_r      <= CNT_ZERO;
            fq_rd_r    <= PTR_ZERO;
            fq_wr_r    <= PTR_ZERO;
            ip_rd_r    <= PTR_ZERO;
            ip_wr_r    <= PTR_ZERO;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_pc_r[i]    <= WORD_ZERO;
                fq_instr_r[i] <= WORD_ZERO;
                ip_pc_r[i]    <= WORD_ZERO;
            end
            imem_req_r <= 1'b0;
            if_valid_r <= 1'b0;
            if_instr_r <= WORD_ZERO;
            if_pc_r    <= WORD_ZERO;
        end else begin
            pc_r       <= pc_nxt_s;
            out_r      <= out_nxt_s;
            drop_r     <= drop_nxt_s;
            cnt_r      <= cnt_nxt_s;
            fq_rd_r    <= fq_rd_nxt_s;
            fq_wr_r    <= fq_wr_nxt_s;
            ip_rd_r    <= ip_rd_nxt_s;
            ip_wr_r    <= ip_wr_nxt_s;
            if (gnt_fire_s && !redir_valid) begin
                ip_pc_r[ip_wr_r] <= pc_r;
            end
            if (push_s) begin
                fq_pc_r[fq_wr_r]    <= ip_pc_r[ip_rd_r];
                fq_instr_r[fq_wr_r] <= imem_rdata;
            end
            imem_req_r <= req_nxt_s;
            if_valid_r <= valid_nxt_s;
            if_instr_r <= if_instr_nxt_s;
            if_pc_r    <= if_pc_nxt_s;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Trap and stall state; the trap register drives if_misalign directly.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            trap_r    <= 1'b0;
            stall_r   <= 1'b0;
            trap_pc_r <= WORD_ZERO;
        end else begin
            trap_r    <= trap_nxt_s;
            stall_r   <= stall_nxt_s;
            trap_pc_r <= trap_pc_nxt_s;
        end
    end

    assign if_misalign = trap_r;
`endif

    // the address output is the PC register itself
    assign imem_req  = imem_req_r;
    assign imem_addr = pc_r;
    assign if_valid  = if_valid_r;
    assign if_instr  = if_instr_r;
    assign if_pc     = if_pc_r;

endmodule
